serial_word_loader: RTL and testbench
=====================================

// Module: serial_word_loader
// PURPOSE
//  Upstream feeder for the Hack CPU 16-bit shift register and instruction ROM write port.
//  Receives program words over an external 3-wire serial link (sclk_i/sdata_i/cs_n_i, async to clk).
//  Assembles words MSB-first and presents each with its ROM address over a valid/ready handshake.
//  Holds one completed word while the next word is shifted in.
// PARAMETERS
//  WORD_W  16  bits per assembled word (Hack instruction width)
//  ADDR_W  15  ROM address width; word address counter wraps at 2**ADDR_W
// PORTS
//  clk          in   1       system clock
//  resetb       in   1       reset, asynchronous, active-low
//  sclk_i       in   1       serial clock, async; data sampled on its rising edge
//  sdata_i      in   1       serial data, async, MSB first
//  cs_n_i       in   1       frame select, async, active-low; falling edge = frame start
//  word_o       out  WORD_W  buffered word
//  addr_o       out  ADDR_W  ROM address bound to word_o
//  valid_o      out  1       word_o/addr_o valid
//  ready_i      in   1       consumer accepts when valid_o & ready_i at posedge clk
//  busy_o       out  1       frame active (synchronised cs_n low)
//  overrun_o    out  1       sticky: a completed word was dropped because the buffer was full
//  parity_err_o out  1       sticky; exists only with LOADER_PARITY_EN
// BEHAVIOUR
//  Reset values: every output 0; shift reg, bit count, word counter, sync flops 0; cs_n syncs reset to 1.
//  Sync: sclk_i, sdata_i, cs_n_i each pass a 2-FF synchroniser; a third sclk flop detects the rising edge.
//  Link constraint: sclk high and low phases each >= 3 clk periods; sdata stable around the sclk rise.
//  FSM: IDLE -> SHIFT on cs_n falling edge; SHIFT -> IDLE on cs_n rising edge.
//  On frame start:
//   - bit count := 0; word counter := 0
//   - overrun_o and parity_err_o cleared
//   - the buffered word, if any, is kept
//  SHIFT: each detected sclk rise -> shreg := {shreg[WORD_W-2:0], sdata_sync}; bit count += 1.
//  Word complete: bit count reaches WORD_W (WORD_W+1 with parity); bit count := 0.
//   - Buffer free (valid_o=0, or valid_o&ready_i in the same cycle):
//     load word_o := shreg and addr_o := word counter; word counter += 1 (mod 2**ADDR_W);
//     valid_o=1 on the next cycle. This is 1 clk after the detected edge.
//   - Buffer full: word dropped, overrun_o := 1, word counter unchanged.
//  Handshake:
//   - valid_o stays high, with word_o/addr_o stable, until a cycle with ready_i=1.
//   - valid_o drops the following cycle unless a new word loads in that same cycle.
//   - ready_i while valid_o=0 is ignored.
//  cs_n rising mid-word: partial bits discarded; bit count := 0; buffered word unaffected.
//  sclk edges while IDLE are ignored. Reset mid-frame: everything returns to reset values.
//  busy_o = (state == SHIFT).
// CONFIGURATION
//  LOADER_PARITY_EN defined:
//   - each word carries a trailing (WORD_W+1)th bit, odd parity over the WORD_W data bits
//   - the parity bit is not stored
//   - mismatch: word dropped, word counter unchanged, parity_err_o := 1 (sticky until next frame start)
//  Undefined: WORD_W bits per word; no parity bit; parity_err_o port absent.
// STRUCTURE
//  Package hack_loader_pkg:
//   - WORD_W/ADDR_W defaults
//   - typedef enum logic {LDR_IDLE, LDR_SHIFT} ldr_state_t
//   - typedefs word_t, rom_addr_t
//  Sub-module bit_sync: 2-FF synchroniser; reset value is a parameter (1 for cs_n).
//   Instantiated 3x.
// TESTING
//  1. cs_n low, shift 0xA5C3, ready_i=1 -> valid_o one clk-cycle pulse;
//     word_o=0xA5C3, addr_o=0; overrun_o=0.
//  2. Frame of 3 words 0x0001,0x8000,0xFFFF, ready_i=1 -> addr_o 0,1,2 in order; words exact.
//  3. ready_i=0, shift 0x1111 then 0x2222 -> valid_o held with 0x1111/addr 0;
//     0x2222 dropped, overrun_o=1.
//     Then ready_i=1 -> valid_o falls. Next frame start -> overrun_o=0.
//  4. Shift 9 bits then raise cs_n; new frame with 0x1234 -> word_o=0x1234, addr_o=0;
//     no stale bits in the word.
//  5. ADDR_W=2, one frame of 5 words, ready_i=1 -> addr_o 0,1,2,3,0.
//  6. LOADER_PARITY_EN: 0x0003+parity 1 -> accepted; 0x0003+parity 0 -> dropped, parity_err_o=1.
//     Assert resetb mid-word -> all outputs 0 immediately.

Source files
------------

// File: rtl/hack_loader_pkg.sv
// Shared types and defaults for the serial program-word loader that feeds
// the Hack CPU instruction ROM write port.
// Optional feature macro: LOADER_PARITY_EN (trailing odd-parity bit per word).
package hack_loader_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int ADDR_W_DEF = 15;

    typedef enum logic {
        LDR_IDLE,
        LDR_SHIFT
    } ldr_state_t;

    typedef logic [WORD_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] rom_addr_t;

endpackage

// File: rtl/serial_word_loader_bit_sync.sv
// Two-flop synchroniser for one asynchronous input bit.
// RST_VAL selects the value both flops take in reset, so an idle-high
// line such as a frame select does not look asserted after reset.
module bit_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetb,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_word_loader.sv
// Serial word loader: assembles MSB-first words from a 3-wire link
// (sclk_i/sdata_i/cs_n_i, asynchronous to clk) and presents each word with
// its ROM address on a valid/ready handshake. One completed word is held
// while the next one shifts in; a word completing while the buffer is still
// full is dropped and flagged on overrun_o.
// Optional feature macro: LOADER_PARITY_EN adds a trailing odd-parity bit
// per word and the parity_err_o output.
//
// state     | meaning
// ----------+-----------------------------------------------
// LDR_IDLE  | no frame; sclk edges ignored
// LDR_SHIFT | frame open; sclk rises shift data into shreg
module serial_word_loader
    import hack_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              sclk_i,
    input  logic              sdata_i,
    input  logic              cs_n_i,
    output logic [WORD_W-1:0] word_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
`ifdef LOADER_PARITY_EN
    output logic              parity_err_o,
`endif
    output logic              overrun_o
);

`ifdef LOADER_PARITY_EN
    localparam int FRAME_BITS = WORD_W + 1;
`else
    localparam int FRAME_BITS = WORD_W;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    // Synchronised link signals and edge detection.
    logic sclk_s;
    logic sdata_s;
    logic cs_n_s;
    logic sclk_q;
    logic cs_n_q;
    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    ldr_state_t state_q, state_d;

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
`ifdef LOADER_PARITY_EN
    logic              perr_q, perr_d;
    logic              parity_slot;
    logic              parity_ok;
`endif

    logic              shift_en;
    logic              data_slot;
    logic              word_done;
    logic [WORD_W-1:0] word_new;
    logic              buf_free;

    bit_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .resetb (resetb),
        .d_i    (sclk_i),
        .q_o    (sclk_s)
    );

    bit_sync #(.RST_VAL(1'b0)) u_sync_sdata (
        .clk    (clk),
        .resetb (resetb),
        .d_i    (sdata_i),
        .q_o    (sdata_s)
    );

    bit_sync #(.RST_VAL(1'b1)) u_sync_cs_n (
        .clk    (clk),
        .resetb (resetb),
        .d_i    (cs_n_i),
        .q_o    (cs_n_s)
    );

    // Delayed copies of the synchronised sclk and cs_n for edge detection.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
        end else begin
            sclk_q <= sclk_s;
            cs_n_q <= cs_n_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign cs_fall   = cs_n_q & ~cs_n_s;
    assign cs_rise   = ~cs_n_q & cs_n_s;

    // Frame state register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= LDR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame state transitions on cs_n edges.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LDR_IDLE:  if (cs_fall) state_d = LDR_SHIFT;
            LDR_SHIFT: if (cs_rise) state_d = LDR_IDLE;
            default:   state_d = LDR_IDLE;
        endcase
    end

    // A cs_n rise in the same cycle as an sclk rise closes the frame first,
    // so that last edge never contributes a bit.
    assign shift_en = (state_q == LDR_SHIFT) && sclk_rise && !cs_rise;
    assign buf_free = !valid_q || ready_i;

    // Word-completion decode; with parity the last slot carries the check bit
    // and the word itself is already complete in shreg.
`ifdef LOADER_PARITY_EN
    assign data_slot   = shift_en && (bit_cnt_q < CNT_W'(WORD_W));
    assign parity_slot = shift_en && (bit_cnt_q == CNT_W'(WORD_W));
    assign parity_ok   = (^shreg_q) ^ sdata_s;
    assign word_done   = parity_slot && parity_ok;
    assign word_new    = shreg_q;
`else
    assign data_slot   = shift_en;
    assign word_done   = shift_en && (bit_cnt_q == CNT_W'(WORD_W - 1));
    assign word_new    = {shreg_q[WORD_W-2:0], sdata_s};
`endif

    // Shift, bit counting, word buffering, handshake and sticky flags.
    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
`ifdef LOADER_PARITY_EN
        perr_d     = perr_q;
`endif

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if ((state_q == LDR_IDLE) && cs_fall) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            overrun_d  = 1'b0;
`ifdef LOADER_PARITY_EN
            perr_d     = 1'b0;
`endif
        end else if ((state_q == LDR_SHIFT) && cs_rise) begin
            bit_cnt_d = '0;
        end else if (shift_en) begin
            if (data_slot) begin
                shreg_d = {shreg_q[WORD_W-2:0], sdata_s};
            end
            if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
`ifdef LOADER_PARITY_EN
            if (parity_slot && !parity_ok) begin
                perr_d = 1'b1;
            end
`endif
            if (word_done) begin
                if (buf_free) begin
                    word_d     = word_new;
                    addr_d     = word_cnt_q;
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    valid_d    = 1'b1;
                end else begin
                    overrun_d  = 1'b1;
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef LOADER_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
`ifdef LOADER_PARITY_EN
            perr_q     <= perr_d;
`endif
        end
    end

    assign word_o    = word_q;
    assign addr_o    = addr_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q == LDR_SHIFT);
`ifdef LOADER_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: a default-size instance and a second one with
// a 2-bit address counter, both on the same serial link and ready_i.
// Expected words and addresses come from a frame-level model: accepted words
// are numbered from zero within each frame.
// Optional feature macro: LOADER_PARITY_EN.
module tb_serial_word_loader;

`ifdef LOADER_PARITY_EN
    localparam int FRAME_BITS = 17;
`else
    localparam int FRAME_BITS = 16;
`endif

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        sclk_i = 1'b0;
    logic        sdata_i = 1'b0;
    logic        cs_n_i = 1'b1;
    logic        ready_i = 1'b0;
    logic [15:0] word_o;
    logic [14:0] addr_o;
    logic        valid_o;
    logic        busy_o;
    logic        overrun_o;
    logic [15:0] word2;
    logic [1:0]  addr2;
    logic        valid2;
    logic        busy2;
    logic        overrun2;
`ifdef LOADER_PARITY_EN
    logic        parity_err_o;
    logic        parity_err2;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] obs_w[$];
    logic [14:0] obs_a[$];
    logic [1:0]  obs_a2[$];
    int          run_len = 0;
    int          max_run = 0;

    always #5 clk = ~clk;

    serial_word_loader dut (
        .clk       (clk),
        .resetb    (resetb),
        .sclk_i    (sclk_i),
        .sdata_i   (sdata_i),
        .cs_n_i    (cs_n_i),
        .word_o    (word_o),
        .addr_o    (addr_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
`ifdef LOADER_PARITY_EN
        .parity_err_o (parity_err_o),
`endif
        .overrun_o (overrun_o)
    );

    serial_word_loader #(.WORD_W(16), .ADDR_W(2)) dut2 (
        .clk       (clk),
        .resetb    (resetb),
        .sclk_i    (sclk_i),
        .sdata_i   (sdata_i),
        .cs_n_i    (cs_n_i),
        .word_o    (word2),
        .addr_o    (addr2),
        .valid_o   (valid2),
        .ready_i   (ready_i),
        .busy_o    (busy2),
`ifdef LOADER_PARITY_EN
        .parity_err_o (parity_err2),
`endif
        .overrun_o (overrun2)
    );

    // Record handshakes and valid run lengths at the falling edge; inputs
    // only change shortly after the rising edge.
    always @(negedge clk) begin
        if (valid_o && ready_i) begin
            obs_w.push_back(word_o);
            obs_a.push_back(addr_o);
        end
        if (valid2 && ready_i) begin
            obs_a2.push_back(addr2);
        end
        if (valid_o) begin
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic shift_bits(input logic [16:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdata_i = v[i];
            tick(4);
            sclk_i = 1'b1;
            tick(4);
            sclk_i = 1'b0;
        end
    endtask

    task automatic send_word(input logic [15:0] w);
`ifdef LOADER_PARITY_EN
        shift_bits({w, ~(^w)}, FRAME_BITS);
`else
        shift_bits({1'b0, w}, FRAME_BITS);
`endif
    endtask

    task automatic frame_start();
        cs_n_i = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        cs_n_i = 1'b1;
        tick(6);
    endtask

    task automatic clear_obs();
        obs_w.delete();
        obs_a.delete();
        obs_a2.delete();
        max_run = 0;
    endtask

    logic [15:0] exp_w[6];
    logic [15:0] w_tmp;
    logic [16:0] junk;

    initial begin
        // Reset values
        tick(3);
        check("rst_valid", valid_o, 0);
        check("rst_word", word_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        resetb = 1'b1;
        tick(3);

        // Single word with consumer ready: one-cycle valid pulse
        ready_i = 1'b1;
        clear_obs();
        frame_start();
        check("t1_busy", busy_o, 1);
        send_word(16'hA5C3);
        tick(8);
        check("t1_count", obs_w.size(), 1);
        if (obs_w.size() > 0) begin
            check("t1_word", obs_w[0], 16'hA5C3);
            check("t1_addr", obs_a[0], 0);
        end
        check("t1_pulse", max_run, 1);
        check("t1_overrun", overrun_o, 0);
        frame_end();
        check("t1_busy_end", busy_o, 0);

        // Six-word frame: directed corner words then random ones
        exp_w[0] = 16'h0001;
        exp_w[1] = 16'h8000;
        exp_w[2] = 16'hFFFF;
        for (int i = 3; i < 6; i++) exp_w[i] = 16'($urandom_range(0, 65535));
        clear_obs();
        frame_start();
        for (int i = 0; i < 6; i++) send_word(exp_w[i]);
        tick(8);
        frame_end();
        check("t2_count", obs_w.size(), 6);
        check("t2_count2", obs_a2.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (obs_w.size() > i) begin
                check($sformatf("t2_word%0d", i), obs_w[i], exp_w[i]);
                check($sformatf("t2_addr%0d", i), obs_a[i], i);
            end
            if (obs_a2.size() > i) begin
                check($sformatf("t2_addr_w2_%0d", i), obs_a2[i], i % 4);
            end
        end
        check("t2_overrun", overrun_o, 0);

        // Consumer stalled: second word is dropped
        ready_i = 1'b0;
        clear_obs();
        frame_start();
        send_word(16'h1111);
        send_word(16'h2222);
        tick(8);
        check("t3_valid_held", valid_o, 1);
        check("t3_word_held", word_o, 16'h1111);
        check("t3_addr_held", addr_o, 0);
        check("t3_overrun", overrun_o, 1);
        ready_i = 1'b1;
        tick(1);
        check("t3_valid_fall", valid_o, 0);
        check("t3_accepted", obs_w.size(), 1);
        check("t3_overrun_sticky", overrun_o, 1);
        frame_end();
        frame_start();
        check("t3_overrun_clr", overrun_o, 0);
        frame_end();

        // Aborted partial word leaves nothing behind
        clear_obs();
        junk = 17'($urandom);
        frame_start();
        shift_bits(junk, 9);
        frame_end();
        check("t4_no_word", obs_w.size(), 0);
        frame_start();
        send_word(16'h1234);
        tick(8);
        frame_end();
        check("t4_count", obs_w.size(), 1);
        if (obs_w.size() > 0) begin
            check("t4_word", obs_w[0], 16'h1234);
            check("t4_addr", obs_a[0], 0);
        end

`ifdef LOADER_PARITY_EN
        // Parity: good word accepted, bad word dropped and flagged
        clear_obs();
        frame_start();
        shift_bits({16'h0003, 1'b1}, 17);
        tick(8);
        check("t6_good_count", obs_w.size(), 1);
        if (obs_w.size() > 0) check("t6_good_word", obs_w[0], 16'h0003);
        check("t6_perr0", parity_err_o, 0);
        shift_bits({16'h0003, 1'b0}, 17);
        tick(8);
        check("t6_bad_count", obs_w.size(), 1);
        check("t6_perr1", parity_err_o, 1);
        send_word(16'h0F0F);
        tick(8);
        check("t6_next_addr", (obs_a.size() > 1) ? 32'(obs_a[1]) : 32'hFFFF, 1);
        frame_end();
        frame_start();
        check("t6_perr_clr", parity_err_o, 0);
        frame_end();
`endif

        // Asynchronous reset mid-word with a word buffered
        ready_i = 1'b0;
        w_tmp = 16'($urandom) | 16'h0001;
        frame_start();
        send_word(w_tmp);
        shift_bits(17'($urandom), 5);
        tick(2);
        check("t7_pre_valid", valid_o, 1);
        check("t7_pre_word", word_o, w_tmp);
        resetb = 1'b0;
        #1;
        check("t7_valid", valid_o, 0);
        check("t7_word", word_o, 0);
        check("t7_addr", addr_o, 0);
        check("t7_busy", busy_o, 0);
        check("t7_overrun", overrun_o, 0);
`ifdef LOADER_PARITY_EN
        check("t7_perr", parity_err_o, 0);
`endif
        cs_n_i = 1'b1;
        tick(3);
        resetb = 1'b1;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
